// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard controller: scancodes, key ids,
// decoder state encoding, event FIFO geometry and prefix timeout length.
package ps2_pkg;

    // Prefix bytes
    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;

    // Scancodes of interest
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_ESC   = 8'h76;

    // Key ids; 0 means "not a tracked key"
    localparam logic [2:0] KEY_NONE  = 3'd0;
    localparam logic [2:0] KEY_UP    = 3'd1;
    localparam logic [2:0] KEY_DOWN  = 3'd2;
    localparam logic [2:0] KEY_LEFT  = 3'd3;
    localparam logic [2:0] KEY_RIGHT = 3'd4;
    localparam logic [2:0] KEY_ENTER = 3'd5;
    localparam logic [2:0] KEY_ESC   = 3'd6;

    localparam int unsigned NUM_KEYS = 6;

    // Decoder states
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StExt    = 2'd1,
        StBrk    = 2'd2,
        StExtBrk = 2'd3
    } ps2_state_e;

    // Event FIFO geometry
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned EV_WIDTH   = 4;

    // Prefix timeout (only used when PS2_KEY_TIMEOUT_EN is defined)
    localparam int unsigned TIMEOUT_WIDTH  = 20;
    localparam int unsigned TIMEOUT_CYCLES = 1 << 20;

    // Map a scancode to a key id. Arrows exist only as extended codes; the
    // non-extended 75/72/6B/74 are keypad keys and map to KEY_NONE.
    function automatic logic [2:0] decode_key(input logic [7:0] code, input logic ext);
        logic [2:0] id;
        id = KEY_NONE;
        if (ext) begin
            unique case (code)
                SC_UP:    id = KEY_UP;
                SC_DOWN:  id = KEY_DOWN;
                SC_LEFT:  id = KEY_LEFT;
                SC_RIGHT: id = KEY_RIGHT;
                default:  id = KEY_NONE;
            endcase
        end else begin
            unique case (code)
                SC_ENTER: id = KEY_ENTER;
                SC_ESC:   id = KEY_ESC;
                default:  id = KEY_NONE;
            endcase
        end
        return id;
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through event FIFO. A push into a full FIFO is dropped and
// sets the sticky ovf flag unless a pop happens in the same cycle.
module ps2_evt_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             ovf
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             ovf_q;
    logic             pop_ok, push_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == CntW'(Depth));

    // Pop on empty is ignored; a pop frees the slot a same-cycle push needs
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Head is zero while empty so the output is clean after reset
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];
    assign ovf      = ovf_q;

    // Storage, pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + CntW'(1);
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - CntW'(1);
            end
            if (push && !push_ok) begin
                ovf_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 key controller: consumes scancode bytes, tracks E0/F0 prefixes, keeps
// live held flags and last arrow direction, and queues make/break events.
// Optional feature: define PS2_KEY_TIMEOUT_EN to abandon a stale prefix after
// TIMEOUT_CYCLES cycles without a byte.
module ps2_key_ctrl
    import ps2_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ack,
    output logic       ev_valid,
    output logic [3:0] ev_data,
    input  logic       ev_ack,
    output logic [5:0] key_held,
    output logic [1:0] dir,
    output logic       ovf
);

    ps2_state_e    state_q, state_d;
    logic          rx_ack_q;
    logic          armed_q;
    logic [5:0]    held_q, held_d;
    logic [1:0]    dir_q, dir_d;
    logic          consume;
    logic          is_ext, is_brk;
    logic [2:0]    key_id;
    logic [5:0]    key_mask;
    logic          ev_push;
    logic [3:0]    ev_push_data;
    logic          fifo_full, fifo_empty;

    // A byte is taken once per rx_valid assertion; armed_q re-opens the input
    // only after the receiver has dropped rx_valid, so a lingering valid is
    // never consumed twice.
    assign consume = rx_valid && !rx_ack_q && armed_q;

    assign is_ext = (state_q == StExt) || (state_q == StExtBrk);
    assign is_brk = (state_q == StBrk) || (state_q == StExtBrk);
    assign key_id = decode_key(rx_data, is_ext);
    assign key_mask = (key_id == KEY_NONE) ? 6'd0 : (6'd1 << (key_id - 3'd1));

`ifdef PS2_KEY_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] tmo_q;
    logic                     tmo_hit;

    assign tmo_hit = (state_q != StIdle) &&
                     (tmo_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

    // Cycles spent waiting in a prefix state; restarted by every byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_q <= '0;
        end else if (consume || (state_q == StIdle) || tmo_hit) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TIMEOUT_WIDTH'(1);
        end
    end
`endif

    // Decoder state, handshake and key status registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            rx_ack_q <= 1'b0;
            armed_q  <= 1'b1;
            held_q   <= '0;
            dir_q    <= '0;
        end else begin
            state_q  <= state_d;
            rx_ack_q <= consume;
            if (consume) begin
                armed_q <= 1'b0;
            end else if (!rx_valid) begin
                armed_q <= 1'b1;
            end
            held_q <= held_d;
            dir_q  <= dir_d;
        end
    end

    // Prefix tracking, key decode and event generation
    always_comb begin
        state_d      = state_q;
        held_d       = held_q;
        dir_d        = dir_q;
        ev_push      = 1'b0;
        ev_push_data = '0;
        if (consume) begin
            if ((state_q == StIdle) && (rx_data == SC_E0)) begin
                state_d = StExt;
            end else if ((state_q == StIdle) && (rx_data == SC_F0)) begin
                state_d = StBrk;
            end else if ((state_q == StExt) && (rx_data == SC_F0)) begin
                state_d = StExtBrk;
            end else begin
                state_d = StIdle;
                if (key_id != KEY_NONE) begin
                    if (is_brk) begin
                        held_d       = held_q & ~key_mask;
                        ev_push      = 1'b1;
                        ev_push_data = {1'b1, key_id};
                    end else begin
                        // Typematic repeats keep the key held but stay silent
                        held_d = held_q | key_mask;
                        if ((held_q & key_mask) == '0) begin
                            ev_push      = 1'b1;
                            ev_push_data = {1'b0, key_id};
                        end
                        if (key_id <= KEY_RIGHT) begin
                            dir_d = key_id[1:0] - 2'd1;
                        end
                    end
                end
            end
        end
`ifdef PS2_KEY_TIMEOUT_EN
        else if (tmo_hit) begin
            state_d = StIdle;
        end
`endif
    end

    ps2_evt_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (EV_WIDTH)
    ) u_evt_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (ev_push),
        .push_data (ev_push_data),
        .pop       (ev_ack),
        .pop_data  (ev_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .ovf       (ovf)
    );

    assign ev_valid = !fifo_empty;
    assign rx_ack   = rx_ack_q;
    assign key_held = held_q;
    assign dir      = dir_q;

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Scoreboard bench for ps2_key_ctrl: expected events are queued as stimulus
// is issued; a monitor pops the FIFO and compares against the queue.
module tb_ps2_key_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ack;
    logic       ev_valid;
    logic [3:0] ev_data;
    logic       ev_ack = 1'b0;
    logic [5:0] key_held;
    logic [1:0] dir;
    logic       ovf;

    int         checks = 0;
    int         errors = 0;
    int         ack_cnt = 0;
    logic [3:0] exp_q[$];
    bit         pop_en = 1'b0;
    bit         man_pop = 1'b0;

    ps2_key_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ack   (rx_ack),
        .ev_valid (ev_valid),
        .ev_data  (ev_data),
        .ev_ack   (ev_ack),
        .key_held (key_held),
        .dir      (dir),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_ack) ack_cnt++;
    end

    // Monitor: compare the FIFO head against the scoreboard, then pop it
    always @(negedge clk) begin
        logic [3:0] e;
        if (pop_en && ev_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL event_unexpected: got %h, required no event", ev_data);
            end else begin
                e = exp_q.pop_front();
                if (ev_data !== e) begin
                    errors++;
                    $display("FAIL event_data: got %h, required %h", ev_data, e);
                end
            end
            ev_ack = 1'b1;
        end else begin
            ev_ack = man_pop;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        pop_en = 1'b0;
        exp_q.delete();
        idle(2);
        rst = 1'b1;
        idle(1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        @(posedge clk);
        #1 rx_data = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (rx_ack) begin
                got = 1'b1;
                break;
            end
        end
        rx_valid = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL rx_ack_timeout: got no ack, required ack for %h", b);
        end
    endtask

    task automatic drain();
        pop_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !ev_valid) break;
        end
        chk("drain_left", exp_q.size(), 0);
        chk("drain_empty", {31'd0, ev_valid}, 0);
    endtask

    initial begin
        int a0;
        // Reset values while held in reset
        #1;
        chk("rst_ev_valid", {31'd0, ev_valid}, 0);
        chk("rst_ev_data", {28'd0, ev_data}, 0);
        chk("rst_rx_ack", {31'd0, rx_ack}, 0);
        chk("rst_key_held", {26'd0, key_held}, 0);
        chk("rst_dir", {30'd0, dir}, 0);
        chk("rst_ovf", {31'd0, ovf}, 0);
        idle(2);
        rst = 1'b1;
        idle(1);

        // Extended up make
        a0 = ack_cnt;
        send_byte(8'hE0);
        send_byte(8'h75);
        idle(2);
        chk("up_acks", ack_cnt - a0, 2);
        chk("up_ev_valid", {31'd0, ev_valid}, 1);
        chk("up_ev_data", {28'd0, ev_data}, 4'h1);
        chk("up_held0", {31'd0, key_held[0]}, 1);
        chk("up_dir", {30'd0, dir}, 0);
        exp_q.push_back(4'h1);
        drain();

        // Typematic repeat suppression then extended break
        do_reset();
        exp_q.push_back(4'h1);
        exp_q.push_back(4'h9);
        pop_en = 1'b1;
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        drain();
        chk("rep_key_held", {26'd0, key_held}, 0);
        chk("rep_dir", {30'd0, dir}, 0);

        // Enter make/break, unknown code ignored
        do_reset();
        exp_q.push_back(4'h5);
        exp_q.push_back(4'hD);
        pop_en = 1'b1;
        send_byte(8'h5A); send_byte(8'hF0); send_byte(8'h5A); send_byte(8'h1C);
        drain();
        chk("ent_key_held", {26'd0, key_held}, 0);

        // Arrows update dir; keypad 75 is not an arrow; esc make/break
        do_reset();
        pop_en = 1'b1;
        exp_q.push_back(4'h2);
        send_byte(8'hE0); send_byte(8'h72);
        idle(1);
        chk("dir_down", {30'd0, dir}, 1);
        exp_q.push_back(4'h3);
        send_byte(8'hE0); send_byte(8'h6B);
        idle(1);
        chk("dir_left", {30'd0, dir}, 2);
        exp_q.push_back(4'h4);
        send_byte(8'hE0); send_byte(8'h74);
        idle(1);
        chk("dir_right", {30'd0, dir}, 3);
        send_byte(8'h75);
        exp_q.push_back(4'h6);
        send_byte(8'h76);
        exp_q.push_back(4'hA);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h72);
        exp_q.push_back(4'hE);
        send_byte(8'hF0); send_byte(8'h76);
        drain();
        chk("arr_dir_keep", {30'd0, dir}, 3);
        chk("arr_key_held", {26'd0, key_held}, 6'b001100);

        // Overflow: five makes without popping
        do_reset();
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'h72);
        send_byte(8'hE0); send_byte(8'h6B);
        send_byte(8'hE0); send_byte(8'h74);
        send_byte(8'h5A);
        idle(2);
        chk("ovf_set", {31'd0, ovf}, 1);
        chk("ovf_head", {28'd0, ev_data}, 4'h1);
        chk("ovf_held", {26'd0, key_held}, 6'b011111);
        // Push and pop together while full
        @(posedge clk);
        #1 man_pop = 1'b1;
        rx_data = 8'h76;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 man_pop = 1'b0;
        rx_valid = 1'b0;
        idle(2);
        chk("full_pushpop_head", {28'd0, ev_data}, 4'h2);
        exp_q.push_back(4'h2);
        exp_q.push_back(4'h3);
        exp_q.push_back(4'h4);
        exp_q.push_back(4'h6);
        drain();
        chk("ovf_sticky", {31'd0, ovf}, 1);

        // Push and pop together while empty: pop ignored
        do_reset();
        @(posedge clk);
        #1 man_pop = 1'b1;
        rx_data = 8'h5A;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 man_pop = 1'b0;
        rx_valid = 1'b0;
        idle(2);
        chk("empty_pushpop_valid", {31'd0, ev_valid}, 1);
        exp_q.push_back(4'h5);
        drain();
        chk("empty_pushpop_ovf", {31'd0, ovf}, 0);

        // rx_valid lingering for three cycles yields one ack
        do_reset();
        pop_en = 1'b1;
        exp_q.push_back(4'h5);
        a0 = ack_cnt;
        @(posedge clk);
        #1 rx_data = 8'h5A;
        rx_valid = 1'b1;
        idle(3);
        rx_valid = 1'b0;
        idle(3);
        chk("hold_one_ack", ack_cnt - a0, 1);
        drain();

        // Reset mid-sequence discards the E0 prefix
        do_reset();
        send_byte(8'hE0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        send_byte(8'h75);
        idle(3);
        chk("midrst_no_event", {31'd0, ev_valid}, 0);
        chk("midrst_key_held", {26'd0, key_held}, 0);
        chk("midrst_dir", {30'd0, dir}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_ctrl.md
PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock; all flops use the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port rx_data, input, 8 bits: scancode byte from the PS/2 receiver.
REQ-004 SHALL have port rx_valid, input, 1 bit: receiver byte-valid, held high until acknowledged.
REQ-005 SHALL have port rx_ack, output, 1 bit: one-cycle pulse to the receiver on byte consumption.
REQ-006 SHALL have port ev_valid, output, 1 bit: event FIFO not empty.
REQ-007 SHALL have port ev_data, output, 4 bits: {break, key_id[2:0]} at the FIFO head.
REQ-008 SHALL have port ev_ack, input, 1 bit: pop the FIFO head when ev_valid=1.
REQ-009 SHALL have port key_held, output, 6 bits: live pressed flags, bit i-1 for key_id i (1..6).
REQ-010 SHALL have port dir, output, 2 bits: last pressed arrow (0 up, 1 down, 2 left, 3 right).
REQ-011 SHALL have port ovf, output, 1 bit: sticky event-drop flag.

Function
REQ-012 SHALL consume a byte when rx_valid=1 and rx_ack=0, registering rx_ack=1 for exactly one cycle after it.
REQ-013 SHALL ignore rx_valid during the rx_ack cycle, so each receiver byte is consumed once.
REQ-014 SHALL implement the FSM states IDLE, EXT (E0 seen), BRK (F0 seen) and EXTBRK (E0 F0 seen).
REQ-015 SHALL make these transitions: IDLE+E0->EXT; IDLE+F0->BRK; EXT+F0->EXTBRK; any other byte->IDLE after decoding.
REQ-016 SHALL decode key_id from extended codes: 75->1 up, 72->2 down, 6B->3 left, 74->4 right.
REQ-017 SHALL decode key_id from non-extended codes: 5A->5 enter, 76->6 esc.
REQ-018 SHALL decode every other code as key_id 0, leave the state at IDLE, and generate no event.
REQ-019 SHALL, on a make (states IDLE or EXT), set key_held[id-1]; if the key is not already held, it pushes {0,id}.
REQ-020 SHALL suppress typematic repeats, so no event is pushed for a key already held.
REQ-021 SHALL, on a break (states BRK or EXTBRK), clear key_held[id-1] and push {1,id}.
REQ-022 SHALL update dir on an arrow make only, with dir valid from the cycle after the rx_ack pulse.
REQ-023 SHALL decode a non-extended 75/72/6B/74 (keypad) as key_id 0.
REQ-024 SHALL implement the event FIFO as 4 deep, first-word-fall-through, with ev_data valid whenever ev_valid=1.
REQ-025 SHALL, on a push when the FIFO is full, drop the new event, set ovf, and leave existing entries intact.
REQ-026 SHALL, on a simultaneous push and pop when full, accept both with the count unchanged.
REQ-027 SHALL, on a simultaneous push and pop when empty, push only (pop ignored).
REQ-028 SHALL keep the FIFO pointers 2 bits wide with wrap-around and the count 3 bits wide (0..4).
REQ-029 SHALL keep ovf set until reset.

Reset
REQ-030 SHALL, while rst=0, force: FSM to IDLE, rx_ack=0, key_held=0, dir=0, FIFO empty (ev_valid=0, ev_data=0), ovf=0.
REQ-031 SHALL, on reset asserted mid-sequence (e.g. after E0), discard the partial sequence; the first byte after release is decoded from IDLE.

Configuration
REQ-032 SHALL, with PS2_KEY_TIMEOUT_EN defined, return the FSM from EXT, BRK or EXTBRK to IDLE without an event when no byte is consumed within TIMEOUT_CYCLES (package constant, 2^20).
REQ-033 SHALL, with PS2_KEY_TIMEOUT_EN defined, reset the 20-bit timeout counter on every consumed byte.
REQ-034 SHALL, without PS2_KEY_TIMEOUT_EN, contain no timeout counter and hold the prefix states indefinitely.

Structure
REQ-035 SHALL take from shared package ps2_pkg: prefix constants (E0, F0), scancode constants, key_id constants, FSM state encoding, FIFO_DEPTH=4, TIMEOUT_CYCLES.
REQ-036 SHALL implement the event FIFO as sub-module ps2_evt_fifo, with push/pop/full/empty/ovf logic, 4-bit data and depth 4.

Verification
REQ-037 SHALL pass: bytes E0,75 -> one rx_ack per byte; ev_data=4'h1, ev_valid=1, key_held[0]=1, dir=0.
REQ-038 SHALL pass: bytes E0,75,E0,75,E0,F0,75 -> exactly two events {0,1} then {1,1}; key_held=0; dir stays 0.
REQ-039 SHALL pass: bytes 5A,F0,5A,1C -> events 4'h5, 4'hD only; 1C produces no event.
REQ-040 SHALL pass: 5 distinct makes (up, down, left, right, enter) with ev_ack=0 -> 4 entries held, ovf=1; pops return 1,2,3,4.
REQ-041 SHALL pass: rx_valid held high 3 cycles for a single byte -> exactly one rx_ack pulse.
REQ-042 SHALL pass: E0 then rst low 1 cycle then 75 -> no event, key_held=0. With PS2_KEY_TIMEOUT_EN: E0, idle 2^20 cycles, 75 -> no event.
